lmq_pcx_sched: RTL and testbench

- Per-thread load-miss-queue (LMQ) sequencer and PCX request scheduler for the 4-thread LSU.
- Tracks each thread's single outstanding load miss through speculation, PCX issue and CPX return.
- Generates the LMQ entry write enables and the one-hot thread select driving the 4:1 LMQ-to-PCX packet mux.
- Meters PCX issue against a credit counter.

---
 rtl/lmq_pcx_sched_if.sv | 32 +++
 rtl/lmq_pcx_sched.sv | 132 +++++++++++++
 tb/tb_lmq_pcx_sched.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lmq_pcx_sched_if.sv
// rtl/lmq_pcx_sched_if.sv - LMQ/PCX scheduler signal bundle
interface lmq_pcx_sched_if #(
  parameter int CRED_W = 3
);
  logic [3:0]        ld_miss_g;
  logic [3:0]        lsu_ld_spec_vld_kill_w2;
  logic              pcx_ld_stall;
  logic              pcx_ld_ack;
  logic              pcx_credit_rtn;
  logic              cpx_ld_rtn_vld;
  logic [1:0]        cpx_ld_rtn_tid;
  logic [3:0]        lmq_enable;
  logic              ld_pcx_rq_vld;
  logic [3:0]        ld_pcx_rq_sel;
  logic [3:0]        lmq_busy;
  logic              ld_alloc_err;
  logic [CRED_W-1:0] pcx_credits;

  modport slave (
    input  ld_miss_g, lsu_ld_spec_vld_kill_w2, pcx_ld_stall, pcx_ld_ack,
           pcx_credit_rtn, cpx_ld_rtn_vld, cpx_ld_rtn_tid,
    output lmq_enable, ld_pcx_rq_vld, ld_pcx_rq_sel, lmq_busy, ld_alloc_err,
           pcx_credits
  );

  modport master (
    output ld_miss_g, lsu_ld_spec_vld_kill_w2, pcx_ld_stall, pcx_ld_ack,
           pcx_credit_rtn, cpx_ld_rtn_vld, cpx_ld_rtn_tid,
    input  lmq_enable, ld_pcx_rq_vld, ld_pcx_rq_sel, lmq_busy, ld_alloc_err,
           pcx_credits
  );
endinterface

// File: rtl/lmq_pcx_sched.sv
// rtl/lmq_pcx_sched.sv - per-thread LMQ sequencer and credit-metered PCX load scheduler
// LMQ_SINGLE_THREAD_EN: keep only thread 0 and drop the round-robin pointer.
module lmq_pcx_sched #(
  parameter int NUM_CREDITS = 2,
  parameter int CRED_W      = 3
) (
  input  logic            clk,
  input  logic            reset,
  lmq_pcx_sched_if.slave  bus
);

`ifdef LMQ_SINGLE_THREAD_EN
  localparam logic [3:0] THR_MASK = 4'b0001;
`else
  localparam logic [3:0] THR_MASK = 4'b1111;
`endif
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(NUM_CREDITS);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SPEC, S_PEND, S_ISSUED, S_WAIT} state_e;

  state_e            state_q [4];
  state_e            state_d [4];
  logic              vld_q, vld_d;
  logic [3:0]        sel_q, sel_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              err_q, err_d;

  logic [3:0] miss, kill, idle, pend, win_oh;
  logic       ack, pick;

  // Masking here makes the unused threads constant IDLE in single-thread builds.
  assign miss = bus.ld_miss_g & THR_MASK;
  assign kill = bus.lsu_ld_spec_vld_kill_w2 & THR_MASK;
  assign ack  = bus.pcx_ld_ack & vld_q;
  assign pick = !vld_q && !bus.pcx_ld_stall && (credits_q != '0) && (pend != 4'b0000);

  always_comb begin
    idle = 4'b0000;
    pend = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      idle[t] = (state_q[t] == S_IDLE);
      pend[t] = (state_q[t] == S_PEND);
    end
  end

`ifdef LMQ_SINGLE_THREAD_EN
  assign win_oh = 4'b0001;
`else
  logic [1:0] ptr_q, ptr_d, win_idx;

  always_comb begin
    logic       found;
    logic [1:0] idx;
    found   = 1'b0;
    idx     = ptr_q;
    win_idx = ptr_q;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && pend[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    ptr_d = pick ? win_idx : ptr_q;
  end

  assign win_oh = 4'b0001 << win_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 2'd3;
    else       ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    for (int t = 0; t < 4; t++) begin
      state_d[t] = state_q[t];
      case (state_q[t])
        S_IDLE:   if (miss[t]) state_d[t] = S_SPEC;
        S_SPEC:   state_d[t] = kill[t] ? S_IDLE : S_PEND;
        S_PEND:   if (pick && win_oh[t]) state_d[t] = S_ISSUED;
        S_ISSUED: if (ack && sel_q[t]) state_d[t] = S_WAIT;
        S_WAIT:   if (bus.cpx_ld_rtn_vld && bus.cpx_ld_rtn_tid == 2'(t)) state_d[t] = S_IDLE;
        default:  state_d[t] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    vld_d     = vld_q;
    sel_d     = sel_q;
    credits_d = credits_q;
    err_d     = (miss & ~idle) != 4'b0000;
    if (ack) begin
      vld_d = 1'b0;
      sel_d = 4'b0000;
    end else if (pick) begin
      vld_d = 1'b1;
      sel_d = win_oh;
    end
    // Simultaneous ack and credit return cancel out.
    if (ack && !bus.pcx_credit_rtn)
      credits_d = credits_q - CRED_ONE;
    else if (!ack && bus.pcx_credit_rtn && credits_q != CRED_MAX)
      credits_d = credits_q + CRED_ONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < 4; t++) state_q[t] <= S_IDLE;
      vld_q     <= 1'b0;
      sel_q     <= 4'b0000;
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else begin
      for (int t = 0; t < 4; t++) state_q[t] <= state_d[t];
      vld_q     <= vld_d;
      sel_q     <= sel_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign bus.lmq_enable    = miss & idle;
  assign bus.lmq_busy      = ~idle & THR_MASK;
  assign bus.ld_pcx_rq_vld = vld_q;
  assign bus.ld_pcx_rq_sel = sel_q;
  assign bus.ld_alloc_err  = err_q;
  assign bus.pcx_credits   = credits_q;

endmodule

// File: tb/tb_lmq_pcx_sched.sv
// tb/tb_lmq_pcx_sched.sv - directed self-checking bench for lmq_pcx_sched
module tb_lmq_pcx_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  lmq_pcx_sched_if #(.CRED_W(3)) bus ();

  lmq_pcx_sched #(.NUM_CREDITS(2), .CRED_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.ld_miss_g               = 4'b0000;
    bus.lsu_ld_spec_vld_kill_w2 = 4'b0000;
    bus.pcx_ld_stall            = 1'b0;
    bus.pcx_ld_ack              = 1'b0;
    bus.pcx_credit_rtn          = 1'b0;
    bus.cpx_ld_rtn_vld          = 1'b0;
    bus.cpx_ld_rtn_tid          = 2'd0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for a request, then acks it one cycle later; s stays 0 on timeout.
  task automatic get_grant(output logic [3:0] s, input logic rtn_credit);
    s = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      if (bus.ld_pcx_rq_vld) begin
        s = bus.ld_pcx_rq_sel;
        break;
      end
      tick();
    end
    if (s != 4'b0000) begin
      tick();
      bus.pcx_ld_ack     = 1'b1;
      bus.pcx_credit_rtn = rtn_credit;
      tick();
      bus.pcx_ld_ack     = 1'b0;
      bus.pcx_credit_rtn = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    total++;
    if ({bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel, bus.lmq_busy, bus.ld_alloc_err} !== 10'b0)
      $display("FAIL reset_outputs: got %b expected 0",
               {bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel, bus.lmq_busy, bus.ld_alloc_err});
    else passed++;
    total++;
    if (bus.pcx_credits !== 3'd2) $display("FAIL reset_credits: got %0d expected 2", bus.pcx_credits);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    do_reset();
    bus.ld_miss_g = 4'b0001;
    #1;
    total++;
    if (bus.lmq_enable !== 4'b0001) $display("FAIL basic_enable: got %b expected 0001", bus.lmq_enable);
    else passed++;
    tick();
    bus.ld_miss_g = 4'b0000;
    total++;
    if (bus.lmq_busy !== 4'b0001) $display("FAIL basic_busy_c1: got %b expected 0001", bus.lmq_busy);
    else passed++;
    tick();
    total++;
    if (bus.ld_pcx_rq_vld !== 1'b0) $display("FAIL basic_vld_c2: got %b expected 0", bus.ld_pcx_rq_vld);
    else passed++;
    tick();
    total++;
    if ({bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel} !== 5'b1_0001)
      $display("FAIL basic_req_c3: got %b expected 10001", {bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel});
    else passed++;
    tick();
    tick();
    bus.pcx_ld_ack = 1'b1;
    tick();
    bus.pcx_ld_ack = 1'b0;
    total++;
    if ({bus.ld_pcx_rq_vld, bus.pcx_credits} !== 4'b0_001)
      $display("FAIL basic_ack_c6: got vld=%b cred=%0d expected vld=0 cred=1",
               bus.ld_pcx_rq_vld, bus.pcx_credits);
    else passed++;
    bus.cpx_ld_rtn_vld = 1'b1;
    bus.cpx_ld_rtn_tid = 2'd0;
    tick();
    bus.cpx_ld_rtn_vld = 1'b0;
    total++;
    if (bus.lmq_busy !== 4'b0000) $display("FAIL basic_return: got %b expected 0000", bus.lmq_busy);
    else passed++;
    bus.pcx_credit_rtn = 1'b1;
    tick();
    bus.pcx_credit_rtn = 1'b0;
    total++;
    if (bus.pcx_credits !== 3'd2) $display("FAIL basic_credit_rtn: got %0d expected 2", bus.pcx_credits);
    else passed++;
  endtask

  task automatic test_kill;
    logic seen;
    do_reset();
    bus.ld_miss_g = 4'b0100;
    tick();
    bus.ld_miss_g = 4'b0000;
    bus.lsu_ld_spec_vld_kill_w2 = 4'b0100;
    total++;
    if (bus.lmq_busy !== 4'b0100) $display("FAIL kill_busy_c1: got %b expected 0100", bus.lmq_busy);
    else passed++;
    tick();
    bus.lsu_ld_spec_vld_kill_w2 = 4'b0000;
    total++;
    if (bus.lmq_busy !== 4'b0000) $display("FAIL kill_busy_c2: got %b expected 0000", bus.lmq_busy);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= bus.ld_pcx_rq_vld;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL kill_no_issue: got vld seen=%b expected 0", seen);
    else passed++;
  endtask

  task automatic test_round_robin;
    logic [3:0] s;
    logic [3:0] exp_order [4];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    bus.ld_miss_g = 4'b1111;
    tick();
    bus.ld_miss_g = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      get_grant(s, 1'b1);
      total++;
      if (s !== exp_order[g]) $display("FAIL rr_grant%0d: got %b expected %b", g, s, exp_order[g]);
      else passed++;
    end
    total++;
    if (bus.pcx_credits !== 3'd2) $display("FAIL rr_credits: got %0d expected 2", bus.pcx_credits);
    else passed++;
    for (int t = 0; t < 4; t++) begin
      bus.cpx_ld_rtn_vld = 1'b1;
      bus.cpx_ld_rtn_tid = 2'(t);
      tick();
    end
    bus.cpx_ld_rtn_vld = 1'b0;
    total++;
    if (bus.lmq_busy !== 4'b0000) $display("FAIL rr_all_returned: got %b expected 0000", bus.lmq_busy);
    else passed++;
    bus.ld_miss_g = 4'b1010;
    tick();
    bus.ld_miss_g = 4'b0000;
    get_grant(s, 1'b1);
    total++;
    if (s !== 4'b0010) $display("FAIL rr_regrant0: got %b expected 0010", s);
    else passed++;
    get_grant(s, 1'b1);
    total++;
    if (s !== 4'b1000) $display("FAIL rr_regrant1: got %b expected 1000", s);
    else passed++;
  endtask

  task automatic test_credits;
    logic [3:0] s;
    logic       seen;
    do_reset();
    bus.ld_miss_g = 4'b0111;
    tick();
    bus.ld_miss_g = 4'b0000;
    get_grant(s, 1'b0);
    total++;
    if (s !== 4'b0001) $display("FAIL cred_grant0: got %b expected 0001", s);
    else passed++;
    get_grant(s, 1'b0);
    total++;
    if (s !== 4'b0010) $display("FAIL cred_grant1: got %b expected 0010", s);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen |= bus.ld_pcx_rq_vld;
      tick();
    end
    total++;
    if ({seen, bus.pcx_credits} !== 4'b0_000)
      $display("FAIL cred_exhausted: got vld seen=%b cred=%0d expected 0/0", seen, bus.pcx_credits);
    else passed++;
    bus.pcx_credit_rtn = 1'b1;
    tick();
    bus.pcx_credit_rtn = 1'b0;
    total++;
    if ({bus.ld_pcx_rq_vld, bus.pcx_credits} !== 4'b0_001)
      $display("FAIL cred_after_rtn: got vld=%b cred=%0d expected vld=0 cred=1",
               bus.ld_pcx_rq_vld, bus.pcx_credits);
    else passed++;
    tick();
    total++;
    if ({bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel} !== 5'b1_0100)
      $display("FAIL cred_third_req: got %b expected 10100", {bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel});
    else passed++;
  endtask

  task automatic test_stall;
    logic seen;
    do_reset();
    bus.pcx_ld_stall = 1'b1;
    bus.ld_miss_g = 4'b0010;
    tick();
    bus.ld_miss_g = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= bus.ld_pcx_rq_vld;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL stall_hold: got vld seen=%b expected 0", seen);
    else passed++;
    bus.pcx_ld_stall = 1'b0;
    tick();
    total++;
    if ({bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel} !== 5'b1_0010)
      $display("FAIL stall_release: got %b expected 10010", {bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel});
    else passed++;
  endtask

  task automatic test_alloc_err_reset;
    logic [3:0] s;
    do_reset();
    bus.ld_miss_g = 4'b0001;
    tick();
    bus.ld_miss_g = 4'b0000;
    get_grant(s, 1'b1);
    bus.ld_miss_g = 4'b0001;
    #1;
    total++;
    if (bus.lmq_enable !== 4'b0000) $display("FAIL err_enable: got %b expected 0000", bus.lmq_enable);
    else passed++;
    tick();
    bus.ld_miss_g = 4'b0000;
    total++;
    if ({bus.ld_alloc_err, bus.lmq_busy} !== 5'b1_0001)
      $display("FAIL err_pulse: got err=%b busy=%b expected err=1 busy=0001",
               bus.ld_alloc_err, bus.lmq_busy);
    else passed++;
    tick();
    total++;
    if (bus.ld_alloc_err !== 1'b0) $display("FAIL err_one_cycle: got %b expected 0", bus.ld_alloc_err);
    else passed++;
    bus.cpx_ld_rtn_vld = 1'b1;
    bus.cpx_ld_rtn_tid = 2'd0;
    bus.ld_miss_g = 4'b0001;
    tick();
    clear_inputs();
    total++;
    if ({bus.ld_alloc_err, bus.lmq_busy} !== 5'b1_0000)
      $display("FAIL rtn_alloc_same: got err=%b busy=%b expected err=1 busy=0000",
               bus.ld_alloc_err, bus.lmq_busy);
    else passed++;
    bus.ld_miss_g = 4'b0011;
    tick();
    bus.ld_miss_g = 4'b0000;
    get_grant(s, 1'b0);
    total++;
    if (s !== 4'b0010) $display("FAIL err_pre_grant: got %b expected 0010", s);
    else passed++;
    tick();
    total++;
    if ({bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel, bus.pcx_credits} !== 8'b1_0001_001)
      $display("FAIL err_pre_state: got %b expected 10001001",
               {bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel, bus.pcx_credits});
    else passed++;
    bus.ld_miss_g = 4'b0010;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel, bus.lmq_busy, bus.ld_alloc_err, bus.pcx_credits} !== 13'b0_0000_0000_0_010)
      $display("FAIL async_reset: got vld=%b sel=%b busy=%b err=%b cred=%0d expected all 0 cred=2",
               bus.ld_pcx_rq_vld, bus.ld_pcx_rq_sel, bus.lmq_busy, bus.ld_alloc_err, bus.pcx_credits);
    else passed++;
    clear_inputs();
    tick();
    reset = 1'b0;
    bus.pcx_ld_ack = 1'b1;
    bus.cpx_ld_rtn_vld = 1'b1;
    bus.cpx_ld_rtn_tid = 2'd1;
    tick();
    clear_inputs();
    total++;
    if ({bus.ld_pcx_rq_vld, bus.lmq_busy, bus.pcx_credits} !== 8'b0_0000_010)
      $display("FAIL unsolicited_ack: got vld=%b busy=%b cred=%0d expected 0/0000/2",
               bus.ld_pcx_rq_vld, bus.lmq_busy, bus.pcx_credits);
    else passed++;
    bus.pcx_credit_rtn = 1'b1;
    tick();
    bus.pcx_credit_rtn = 1'b0;
    total++;
    if (bus.pcx_credits !== 3'd2) $display("FAIL credit_saturate: got %0d expected 2", bus.pcx_credits);
    else passed++;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_kill();
    test_round_robin();
    test_credits();
    test_stall();
    test_alloc_err_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
